// File: rtl/hazard_scoreboard.sv
// hazard_scoreboard
//   Scoreboard-based hazard detection for the ID stage. Each architectural register
//   has a countdown of cycles until its in-flight result can be consumed; an ID
//   instruction whose used sources are still pending is held back.
//
// Ports
//   clk, rst          clock, synchronous active-high reset
//   id_valid          valid instruction present in ID
//   src1/src1_en      first source register and its read enable
//   src2/src2_en      second source register and its read enable
//   dest/wb_en        destination register and its write enable
//   lat               cycles from issue until writeback of dest (0 = untracked)
//   ext_stall         downstream freeze; all countdowns hold
//   flush             pipeline flush; clears all countdowns, blocks issue
//   hazard_detected   a used source is still pending (combinational)
//   issue             instruction leaves ID this cycle (combinational)
//   busy_mask         bit r set while register r has a nonzero countdown
module hazard_scoreboard #(
  parameter int unsigned ADDR_W     = 4,
  parameter int unsigned CNT_W      = 3,
  parameter bit          FORWARD_EN = 1'b1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     id_valid,
  input  logic [ADDR_W-1:0]        src1,
  input  logic                     src1_en,
  input  logic [ADDR_W-1:0]        src2,
  input  logic                     src2_en,
  input  logic [ADDR_W-1:0]        dest,
  input  logic                     wb_en,
  input  logic [CNT_W-1:0]         lat,
  input  logic                     ext_stall,
  input  logic                     flush,
  output logic                     hazard_detected,
  output logic                     issue,
  output logic [(2**ADDR_W)-1:0]   busy_mask
);

  localparam int unsigned NumRegs = 2 ** ADDR_W;
  // With forwarding a result is consumable when one cycle remains before writeback.
  localparam logic [CNT_W-1:0] Thr = FORWARD_EN ? CNT_W'(1) : '0;

  logic [CNT_W-1:0] cnt_q   [NumRegs];
  logic [CNT_W-1:0] cnt_d   [NumRegs];
  logic [CNT_W-1:0] cnt_dec [NumRegs];

  logic src1_haz;
  logic src2_haz;

  // Sources are checked against the pre-update counters, so src == dest sees the old value.
  always_comb begin
    src1_haz        = src1_en && (cnt_q[src1] > Thr);
    src2_haz        = src2_en && (cnt_q[src2] > Thr);
    hazard_detected = id_valid && !flush && (src1_haz || src2_haz);
    issue           = id_valid && !hazard_detected && !ext_stall && !flush;
  end

  always_comb begin
    for (int unsigned r = 0; r < NumRegs; r++) begin
      cnt_dec[r] = (cnt_q[r] == '0) ? '0 : cnt_q[r] - CNT_W'(1);
    end

    if (flush) begin
      for (int unsigned r = 0; r < NumRegs; r++) cnt_d[r] = '0;
    end else if (ext_stall) begin
      for (int unsigned r = 0; r < NumRegs; r++) cnt_d[r] = cnt_q[r];
    end else begin
      for (int unsigned r = 0; r < NumRegs; r++) cnt_d[r] = cnt_dec[r];
      // WAW: keep whichever outstanding write to dest finishes last.
      if (issue && wb_en && (lat != '0)) begin
        cnt_d[dest] = (lat > cnt_dec[dest]) ? lat : cnt_dec[dest];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned r = 0; r < NumRegs; r++) cnt_q[r] <= '0;
    end else begin
      for (int unsigned r = 0; r < NumRegs; r++) cnt_q[r] <= cnt_d[r];
    end
  end

  always_comb begin
    for (int unsigned r = 0; r < NumRegs; r++) busy_mask[r] = (cnt_q[r] != '0);
  end

endmodule
